// File: rtl/seg_display_driver.sv
// ---------------------------------------------------------------------------
// seg_display_driver
//
// Converts a 16-bit unsigned result to display digits and scans four
// multiplexed seven-segment digits.
//
// Conversion: a load (accepted only while idle) captures value/hex_mode.
// This starts a 16-iteration shift-and-add-3 into five BCD digits. Hex mode
// runs the same 16 cycles, then takes the captured nibbles. The digit
// registers update on the edge where busy falls.
//
// Scan: a free-running refresh counter advances the digit index every
// REFRESH_DIV clocks. an/seg are registered from the index and digit
// registers.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   value    in   [15:0] unsigned value to display
//   load     in   capture request for value / hex_mode
//   hex_mode in   1 = hexadecimal, 0 = decimal with leading-zero blanking
//   blank    in   force all digits dark (display path only)
//   busy     out  conversion in progress
//   seg      out  [6:0] active-low segments, seg[0]=a .. seg[6]=g
//   an       out  [3:0] active-low digit enables, an[0] = rightmost digit
//   dp       out  decimal point, always off (1)
// ---------------------------------------------------------------------------
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        hex_mode,
  input  logic        blank,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_iter;
  logic              w_start, w_last;

  logic [15:0]       r_val;
  logic              r_hex_cap;
  logic [35:0]       r_sr;        // {5 BCD digits, binary shift-in}
  logic [35:0]       w_sr_adj, w_sr_nxt;

  logic [15:0]       r_dig;
  logic              r_dig_hex;
  logic              r_dig_over;

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_idx;

  logic [3:0]        w_nib;
  logic              w_lead_zero;
  logic [6:0]        w_seg_nxt;
  logic [3:0]        w_an_nxt;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
  function automatic logic [35:0] dabble_adjust(input logic [35:0] sr);
    logic [35:0] res;
    res = sr;
    for (int k = 0; k < 5; k++) begin
      if (sr[16 + 4*k +: 4] >= 4'd5) begin
        res[16 + 4*k +: 4] = sr[16 + 4*k +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // ---- conversion control ----
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_start     = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_iter == 4'd15) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_iter <= 4'd0;
      end else if (r_state == S_CONV) begin
        r_iter <= r_iter + 4'd1;
      end
    end
  end

  assign busy = (r_state == S_CONV);

  // ---- conversion datapath ----
  assign w_sr_adj = dabble_adjust(r_sr);
  assign w_sr_nxt = w_sr_adj << 1;

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_val     <= value;
      r_hex_cap <= hex_mode;
      r_sr      <= {20'd0, value};
    end else if (r_state == S_CONV) begin
      r_sr <= w_sr_nxt;
    end
  end

  // ---- displayed digit registers, written as busy falls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig      <= 16'd0;
      r_dig_hex  <= 1'b0;
      r_dig_over <= 1'b0;
    end else if (w_last) begin
      if (r_hex_cap) begin
        r_dig      <= r_val;
        r_dig_hex  <= 1'b1;
        r_dig_over <= 1'b0;
      end else begin
        r_dig      <= w_sr_nxt[31:16];
        r_dig_hex  <= 1'b0;
        r_dig_over <= |w_sr_nxt[35:32];
      end
    end
  end

  // ---- refresh counter and scan index ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---- digit decode and registered outputs ----
  always_comb begin
    w_nib       = r_dig[{r_idx, 2'b00} +: 4];
    // Blank this digit when it and every digit above it are zero;
    // digit 0 always shows so that a value of 0 reads "0".
    w_lead_zero = (r_idx != 2'd0) && ((r_dig >> {r_idx, 2'b00}) == 16'd0);
    w_an_nxt    = ~(4'b0001 << r_idx);
    w_seg_nxt   = glyph(w_nib);
    if (blank) begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'b1111111;
    end else if (!r_dig_hex) begin
      if (r_dig_over) begin
        w_seg_nxt = 7'b0111111;
      end else if (w_lead_zero) begin
        w_seg_nxt = 7'b1111111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'b1000000;
      r_an  <= 4'b1110;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_display_driver
//
// Directed and randomized loads against a reference model of the display.
// The model keeps the value currently shown and derives each digit's glyph
// with plain decimal/hex arithmetic. The scan slot comes from the number of
// clock edges since reset. REFRESH_DIV = 4, so one slot is 4 clocks and a
// full scan is 16 clocks.
// ---------------------------------------------------------------------------
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic        blank;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  seg_display_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .blank    (blank),
    .busy     (busy),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state
  int m_val  = 0;    // value currently shown
  bit m_hex  = 0;
  int m_k    = 0;    // rising edges since reset release
  bit m_blank_edge = 0;  // blank as seen at the most recent edge

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      10:      return 7'b0001000;
      11:      return 7'b0000011;
      12:      return 7'b1000110;
      13:      return 7'b0100001;
      14:      return 7'b0000110;
      15:      return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg_at(input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (m_hex) return glyph((m_val >> (4 * idx)) & 15);
    if (m_val > 9999) return 7'b0111111;
    if (idx != 0 && m_val < p) return 7'b1111111;
    return glyph((m_val / p) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, m_k);
    end
  endtask

  task automatic tick();
    logic b;
    b = blank;
    @(posedge clk);
    if (rst_n) begin
      m_k++;
      m_blank_edge = b;
    end else begin
      m_k = 0;
      m_blank_edge = 0;
    end
    #1;
  endtask

  task automatic check_disp();
    int         idx;
    logic [3:0] ea;
    logic [6:0] es;
    idx = (m_k == 0) ? 0 : ((m_k - 1) / 4) % 4;
    if (m_blank_edge) begin
      ea = 4'b1111;
      es = 7'b1111111;
    end else begin
      ea = ~(4'b0001 << idx);
      es = exp_seg_at(idx);
    end
    check("an", {28'd0, an}, {28'd0, ea});
    check("seg", {25'd0, seg}, {25'd0, es});
    check("dp", {31'd0, dp}, 32'd1);
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_disp();
      check("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  // Load v; with ign set, a second load of 8 is attempted on busy cycle 3.
  task automatic do_load(input int v, input bit h, input bit ign);
    int n;
    value    = 16'(v);
    hex_mode = h;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    value    = 16'($urandom);
    hex_mode = 1'($urandom);
    check_disp();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (ign && n == 3) begin
        value    = 16'd8;
        hex_mode = 1'b0;
        load     = 1'b1;
      end
      tick();
      load = 1'b0;
      check_disp();
    end
    check("busy_len", n, 16);
    m_val = v;
    m_hex = h;
  endtask

  initial begin
    int mode;
    int v;
    bit h;

    rst_n    = 1'b0;
    value    = 16'd0;
    load     = 1'b0;
    hex_mode = 1'b0;
    blank    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_disp();
    @(negedge clk);
    rst_n = 1'b1;
    scan(4);

    // Directed patterns
    do_load(1234, 1'b0, 1'b0);
    scan(16);
    do_load(16'h00AF, 1'b1, 1'b0);
    scan(16);
    do_load(7, 1'b0, 1'b0);
    scan(16);
    do_load(0, 1'b0, 1'b0);
    scan(16);
    do_load(12000, 1'b0, 1'b0);
    scan(16);
    do_load(9999, 1'b0, 1'b0);
    scan(16);
    do_load(10000, 1'b0, 1'b0);
    scan(16);

    // Load during busy is ignored
    do_load(5, 1'b0, 1'b1);
    scan(16);

    // Reset during a conversion
    value    = 16'd4321;
    hex_mode = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_an", {28'd0, an}, 32'h0000000E);
    check("rst_mid_seg", {25'd0, seg}, 32'h00000040);
    m_k = 0;
    m_blank_edge = 0;
    m_val = 0;
    m_hex = 0;
    tick();
    check_disp();
    @(negedge clk);
    rst_n = 1'b1;
    do_load(42, 1'b0, 1'b0);
    scan(16);

    // Blank for 10 cycles; scan position keeps advancing underneath
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_disp();
    end
    blank = 1'b0;
    scan(20);

    // Randomized loads
    for (int r = 0; r < 12; r++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       begin v = $urandom_range(0, 65535);     h = 1'b1; end
        1:       begin v = $urandom_range(0, 9999);      h = 1'b0; end
        2:       begin v = $urandom_range(0, 99);        h = 1'b0; end
        default: begin v = $urandom_range(10000, 65535); h = 1'b0; end
      endcase
      do_load(v, h, 1'($urandom_range(0, 1)));
      scan(16 + $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles per digit scan slot (1 kHz slot rate at 100 MHz).
REQ-003 Port clk, input, 1, SHALL be the system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port value, input, 16, SHALL carry the unsigned result from the calculator stage.
REQ-006 Port load, input, 1, SHALL request capture of value and hex_mode.
REQ-007 Port hex_mode, input, 1, SHALL select the display format: 1 = hexadecimal, 0 = decimal.
REQ-008 Port blank, input, 1, SHALL force all digits dark while high.
REQ-009 Port busy, output, 1, SHALL be high while a conversion is in progress.
REQ-010 Port seg, output, 7, SHALL drive the active-low segments, seg[0]=a ... seg[6]=g.
REQ-011 Port an, output, 4, SHALL drive the active-low digit enables; an[0] is the rightmost (least significant) digit.
REQ-012 Port dp, output, 1, SHALL be held at constant 1 (decimal point off).

Function
REQ-013 A load with busy=0 at edge N SHALL capture value and hex_mode; busy SHALL then be 1 for cycles N+1..N+16.
REQ-014 Conversion SHALL be a sequential 16-iteration shift-and-add-3 (double dabble) into 5 BCD digits; hex_mode SHALL use the same 16-cycle path, and the 4 digits SHALL then be the value nibbles.
REQ-015 The displayed digit registers SHALL update at the edge where busy falls; new digits SHALL reach seg from cycle N+17, or later when the scan position requires it.
REQ-016 A load while busy=1 SHALL be ignored; the in-progress conversion SHALL complete unchanged.
REQ-017 In decimal mode with value > 9999 (nonzero ten-thousands digit), all four digits SHALL show a dash (seg=0111111).
REQ-018 In decimal mode, leading zeros SHALL be blanked (seg=1111111) above the most significant nonzero digit; value 0 SHALL show a single "0" on digit 0.
REQ-019 Hex mode SHALL show all four digits without zero suppression.
REQ-020 Glyphs SHALL be encoded as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-022 an SHALL be one-hot low at the current index; an and seg SHALL be registered and change together, one cycle after the index changes.
REQ-023 When blank=1, the outputs SHALL be an=1111 and seg=1111111 one cycle later; the counter, the index and any conversion SHALL continue unaffected.
REQ-024 The refresh counter SHALL keep running while busy=1; during conversion the display SHALL show the previous digits.

Reset
REQ-025 On rst_n=0, the block SHALL immediately set busy=0, refresh counter=0, index=0, digit registers=0 in decimal mode, an=1110, seg=1000000 and dp=1.
REQ-026 Reset asserted mid-conversion SHALL abandon the conversion; after release the block SHALL accept a new load on the first edge.

Verification (REFRESH_DIV=4)
REQ-027 Apply load, value=1234, hex_mode=0 -> busy high for exactly 16 cycles; over one 16-cycle scan, an0=4 (0011001), an1=3, an2=2, an3=1.
REQ-028 Apply load, value=0x00AF, hex_mode=1 -> digits 0,0,A,F on an3..an0 with no zero suppression.
REQ-029 Apply load of 7 in decimal mode -> an0 shows 1111000; an1..an3 show 1111111. Then load 0 -> only an0 shows 1000000.
REQ-030 Apply load 12000 in decimal mode -> all four slots show 0111111. Then load 9999 -> every slot shows 0010000.
REQ-031 Load 5, then at busy cycle 3 load 8 -> 5 is displayed and 8 is ignored; rst_n pulsed during a conversion -> busy=0, an=1110, seg=1000000 immediately.
REQ-032 Hold blank=1 for 10 cycles -> an=1111; the index keeps advancing, so after release the scan resumes at the expected slot.
